// File: rtl/commit_pkg.sv
// Shared types for the commit stage: ROB head entry layout, trap vector, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package commit_pkg;

    localparam int COMMIT_WIDTH = 2;
    localparam int AREG_W       = 5;
    localparam int PREG_W       = 6;
    localparam int PC_W         = 32;
    localparam int ECODE_W      = 6;
    localparam int IDX_W        = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    // Every exception redirects here; the handler reads the cause from excp_code_o.
    localparam logic [PC_W-1:0] TRAP_VECTOR = 32'h8000_0000;

    typedef struct packed {
        logic               complete;
        logic               exception;
        logic [ECODE_W-1:0] ecode;
        logic               mispredict;
        logic               is_store;
        logic               has_dest;
        logic [AREG_W-1:0]  areg;
        logic [PREG_W-1:0]  preg;
        logic [PREG_W-1:0]  old_preg;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    target;
    } commit_entry_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } commit_state_t;

endpackage

// File: rtl/commit_select.sv
// Picks the longest retirable prefix of the ROB head, plus the store and terminal slots.
// Latency: purely combinational.
// Backpressure: a store that is not accepted by the store buffer blocks itself and all younger slots.
import commit_pkg::*;

module commit_select (
    input  logic [COMMIT_WIDTH-1:0] valid,
    input  logic [COMMIT_WIDTH-1:0] complete,
    input  logic [COMMIT_WIDTH-1:0] exception,
    input  logic [COMMIT_WIDTH-1:0] mispredict,
    input  logic [COMMIT_WIDTH-1:0] is_store,
    input  logic                    store_ready,
    output logic [COMMIT_WIDTH-1:0] elig,
    output logic                    store_vld,
    output logic                    term_vld,
    output logic [IDX_W-1:0]        term_idx
);

    logic chain;
    logic seen_store;
    logic ok;
    logic real_store;

    // Walk oldest to youngest; chain drops at the first blocked or terminal slot.
    always_comb begin
        elig       = '0;
        store_vld  = 1'b0;
        term_vld   = 1'b0;
        term_idx   = '0;
        chain      = 1'b1;
        seen_store = 1'b0;
        ok         = 1'b0;
        real_store = 1'b0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            // A faulting store never reaches the store buffer, so it is not a store here.
            real_store = is_store[k] && !exception[k];
            ok         = chain && valid[k] && complete[k];
            if (ok && real_store && !seen_store) begin
                store_vld = 1'b1;
            end
            elig[k] = ok && (!real_store || (!seen_store && store_ready));
            if (elig[k] && (exception[k] || mispredict[k])) begin
                term_vld = 1'b1;
                term_idx = IDX_W'(k);
            end
            if (ok && real_store) begin
                seen_store = 1'b1;
            end
            chain = elig[k] && !exception[k] && !mispredict[k];
        end
    end

endmodule

// File: rtl/commit_stage.sv
// In-order retirement: pops the eligible ROB prefix, writes the rename table, frees old pregs, flushes on terminals.
// Latency: pop/store_valid combinational; arch/free/flush/redirect/excp one cycle after the pop.
// Backpressure: store_ready_i low stalls the first store and everything younger; no pops during the flush cycle.
import commit_pkg::*;

module commit_stage (
    input  logic                                 clk,
    input  logic                                 rst,
    input  commit_entry_t [COMMIT_WIDTH-1:0]     rob_entry_i,
    input  logic [COMMIT_WIDTH-1:0]              rob_valid_i,
    output logic [COMMIT_WIDTH-1:0]              rob_pop_o,
    output logic                                 store_valid_o,
    input  logic                                 store_ready_i,
    output logic [COMMIT_WIDTH-1:0]              arch_we_o,
    output logic [COMMIT_WIDTH-1:0][AREG_W-1:0]  arch_areg_o,
    output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  arch_preg_o,
    output logic [COMMIT_WIDTH-1:0]              free_valid_o,
    output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  free_preg_o,
    output logic                                 flush_o,
    output logic                                 redirect_valid_o,
    output logic [PC_W-1:0]                      redirect_pc_o,
    output logic                                 excp_valid_o,
    output logic [ECODE_W-1:0]                   excp_code_o,
    output logic [PC_W-1:0]                      excp_pc_o
);

    commit_state_t state_q, state_d;

    logic [COMMIT_WIDTH-1:0] complete_v, exception_v, mispredict_v, is_store_v;
    logic [COMMIT_WIDTH-1:0] elig;
    logic                    sel_store_vld;
    logic                    term_vld;
    logic [IDX_W-1:0]        term_idx;
    logic                    pop_en;
    logic                    term_fire;
    commit_entry_t           term_entry;

    // Flatten per-slot flags for the selector.
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            complete_v[k]   = rob_entry_i[k].complete;
            exception_v[k]  = rob_entry_i[k].exception;
            mispredict_v[k] = rob_entry_i[k].mispredict;
            is_store_v[k]   = rob_entry_i[k].is_store;
        end
    end

    commit_select u_select (
        .valid       (rob_valid_i),
        .complete    (complete_v),
        .exception   (exception_v),
        .mispredict  (mispredict_v),
        .is_store    (is_store_v),
        .store_ready (store_ready_i),
        .elig        (elig),
        .store_vld   (sel_store_vld),
        .term_vld    (term_vld),
        .term_idx    (term_idx)
    );

    assign pop_en        = !rst && (state_q == ST_RUN);
    assign rob_pop_o     = pop_en ? elig : '0;
    assign store_valid_o = pop_en && sel_store_vld;
    assign term_fire     = pop_en && term_vld;
    assign term_entry    = rob_entry_i[term_idx];

    assign flush_o          = (state_q == ST_FLUSH);
    assign redirect_valid_o = (state_q == ST_FLUSH);

    // State register; reset also discards a flush that is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a retiring terminal buys exactly one flush cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (term_fire) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Retirement side effects, registered one cycle after the pop; data is zero when not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            arch_we_o     <= '0;
            arch_areg_o   <= '0;
            arch_preg_o   <= '0;
            free_valid_o  <= '0;
            free_preg_o   <= '0;
            redirect_pc_o <= '0;
            excp_valid_o  <= 1'b0;
            excp_code_o   <= '0;
            excp_pc_o     <= '0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (rob_pop_o[k] && rob_entry_i[k].has_dest && !rob_entry_i[k].exception) begin
                    arch_we_o[k]    <= 1'b1;
                    arch_areg_o[k]  <= rob_entry_i[k].areg;
                    arch_preg_o[k]  <= rob_entry_i[k].preg;
                    free_valid_o[k] <= 1'b1;
                    free_preg_o[k]  <= rob_entry_i[k].old_preg;
                end else begin
                    arch_we_o[k]    <= 1'b0;
                    arch_areg_o[k]  <= '0;
                    arch_preg_o[k]  <= '0;
                    free_valid_o[k] <= 1'b0;
                    free_preg_o[k]  <= '0;
                end
            end
            if (term_fire) begin
                redirect_pc_o <= term_entry.exception ? TRAP_VECTOR : term_entry.target;
                excp_valid_o  <= term_entry.exception;
                excp_code_o   <= term_entry.exception ? term_entry.ecode : '0;
                excp_pc_o     <= term_entry.exception ? term_entry.pc : '0;
            end else begin
                redirect_pc_o <= '0;
                excp_valid_o  <= 1'b0;
                excp_code_o   <= '0;
                excp_pc_o     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage with a per-cycle expectation queue and a decoupled monitor.
// Latency: each record holds that cycle's combinational outputs and registered results of the previous cycle.
// Backpressure: store_ready_i driven per vector.
import commit_pkg::*;

module tb_commit_stage;

    logic                                clk = 1'b0;
    logic                                rst;
    commit_entry_t [COMMIT_WIDTH-1:0]    rob_entry_i;
    logic [COMMIT_WIDTH-1:0]             rob_valid_i;
    logic [COMMIT_WIDTH-1:0]             rob_pop_o;
    logic                                store_valid_o;
    logic                                store_ready_i;
    logic [COMMIT_WIDTH-1:0]             arch_we_o;
    logic [COMMIT_WIDTH-1:0][AREG_W-1:0] arch_areg_o;
    logic [COMMIT_WIDTH-1:0][PREG_W-1:0] arch_preg_o;
    logic [COMMIT_WIDTH-1:0]             free_valid_o;
    logic [COMMIT_WIDTH-1:0][PREG_W-1:0] free_preg_o;
    logic                                flush_o;
    logic                                redirect_valid_o;
    logic [PC_W-1:0]                     redirect_pc_o;
    logic                                excp_valid_o;
    logic [ECODE_W-1:0]                  excp_code_o;
    logic [PC_W-1:0]                     excp_pc_o;

    always #5 clk = ~clk;

    commit_stage dut (
        .clk              (clk),
        .rst              (rst),
        .rob_entry_i      (rob_entry_i),
        .rob_valid_i      (rob_valid_i),
        .rob_pop_o        (rob_pop_o),
        .store_valid_o    (store_valid_o),
        .store_ready_i    (store_ready_i),
        .arch_we_o        (arch_we_o),
        .arch_areg_o      (arch_areg_o),
        .arch_preg_o      (arch_preg_o),
        .free_valid_o     (free_valid_o),
        .free_preg_o      (free_preg_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .excp_valid_o     (excp_valid_o),
        .excp_code_o      (excp_code_o),
        .excp_pc_o        (excp_pc_o)
    );

    typedef struct {
        logic          rst;
        commit_entry_t e0;
        commit_entry_t e1;
        logic [1:0]    vld;
        logic          rdy;
        logic [1:0]    pop;
        logic          stv;
        logic [1:0]    we;
        logic [9:0]    areg;
        logic [11:0]   preg;
        logic [1:0]    fv;
        logic [11:0]   fp;
        logic          fl;
        logic [31:0]   rpc;
        logic          ev;
        logic [5:0]    ec;
        logic [31:0]   epc;
    } vec_t;

    vec_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic commit_entry_t mk(logic c, logic x, logic [5:0] ec, logic m, logic s, logic d,
                                         logic [4:0] a, logic [5:0] p, logic [5:0] op,
                                         logic [31:0] pc, logic [31:0] tg);
        commit_entry_t e;
        e.complete = c; e.exception = x; e.ecode = ec; e.mispredict = m; e.is_store = s;
        e.has_dest = d; e.areg = a; e.preg = p; e.old_preg = op; e.pc = pc; e.target = tg;
        return e;
    endfunction

    // New vector with inputs and combinational expectations; registered expectations default to zero.
    function automatic vec_t nv(logic r, commit_entry_t e0, commit_entry_t e1, logic [1:0] vld,
                                logic rdy, logic [1:0] pop, logic stv);
        vec_t v;
        v.rst = r; v.e0 = e0; v.e1 = e1; v.vld = vld; v.rdy = rdy; v.pop = pop; v.stv = stv;
        v.we = '0; v.areg = '0; v.preg = '0; v.fv = '0; v.fp = '0;
        v.fl = 1'b0; v.rpc = '0; v.ev = 1'b0; v.ec = '0; v.epc = '0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst           = v.rst;
        rob_entry_i   = {v.e1, v.e0};
        rob_valid_i   = v.vld;
        store_ready_i = v.rdy;
        q.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec%0d %s: got %h expected %h", n_vec, name, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents each cycle against the oldest expectation.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk("rob_pop",        64'(rob_pop_o),        64'(e.pop));
                chk("store_valid",    64'(store_valid_o),    64'(e.stv));
                chk("arch_we",        64'(arch_we_o),        64'(e.we));
                chk("arch_areg",      64'(arch_areg_o),      64'(e.areg));
                chk("arch_preg",      64'(arch_preg_o),      64'(e.preg));
                chk("free_valid",     64'(free_valid_o),     64'(e.fv));
                chk("free_preg",      64'(free_preg_o),      64'(e.fp));
                chk("flush",          64'(flush_o),          64'(e.fl));
                chk("redirect_valid", 64'(redirect_valid_o), 64'(e.fl));
                chk("redirect_pc",    64'(redirect_pc_o),    64'(e.rpc));
                chk("excp_valid",     64'(excp_valid_o),     64'(e.ev));
                chk("excp_code",      64'(excp_code_o),      64'(e.ec));
                chk("excp_pc",        64'(excp_pc_o),        64'(e.epc));
            end
        end
    end

    initial begin
        commit_entry_t z, a0, a1, i0, s0, s1, m0, x1;
        vec_t v;
        int   wait_cyc;

        z  = '0;
        a0 = mk(1, 0, 6'h00, 0, 0, 1, 5'd3, 6'd10, 6'd2,  32'h0000_1000, 32'h0);
        a1 = mk(1, 0, 6'h00, 0, 0, 1, 5'd4, 6'd11, 6'd5,  32'h0000_1004, 32'h0);
        i0 = a0; i0.complete = 1'b0;
        s0 = mk(1, 0, 6'h00, 0, 1, 0, 5'd0, 6'd0,  6'd0,  32'h0000_2000, 32'h0);
        s1 = mk(1, 0, 6'h00, 0, 1, 0, 5'd0, 6'd0,  6'd0,  32'h0000_2004, 32'h0);
        m0 = mk(1, 0, 6'h00, 1, 0, 1, 5'd7, 6'd20, 6'd13, 32'h0000_3000, 32'h8000_0100);
        x1 = mk(1, 1, 6'h0B, 0, 1, 1, 5'd9, 6'd30, 6'd31, 32'h0000_1004, 32'h0);

        rst = 1'b1; rob_entry_i = '0; rob_valid_i = '0; store_ready_i = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state: everything zero, no pop even with a retirable head.
        apply(nv(1, a0, a1, 2'b11, 1, 2'b00, 0));
        // Two plain ALU ops.
        apply(nv(0, a0, a1, 2'b11, 0, 2'b11, 0));
        // Incomplete slot 0 blocks; previous pair's writes appear.
        v = nv(0, i0, a1, 2'b11, 0, 2'b00, 0);
        v.we = 2'b11; v.areg = {5'd4, 5'd3}; v.preg = {6'd11, 6'd10}; v.fv = 2'b11; v.fp = {6'd5, 6'd2};
        apply(v);
        apply(nv(0, i0, a1, 2'b11, 0, 2'b00, 0));
        apply(nv(0, a0, a1, 2'b11, 0, 2'b11, 0));
        // Two stores, ready low then high.
        v = nv(0, s0, s1, 2'b11, 0, 2'b00, 1);
        v.we = 2'b11; v.areg = {5'd4, 5'd3}; v.preg = {6'd11, 6'd10}; v.fv = 2'b11; v.fp = {6'd5, 6'd2};
        apply(v);
        apply(nv(0, s0, s1, 2'b11, 1, 2'b01, 1));
        apply(nv(0, s1, z,  2'b01, 1, 2'b01, 1));
        apply(nv(0, z,  z,  2'b00, 1, 2'b00, 0));
        // Mispredict in slot 0 stops the group.
        apply(nv(0, m0, a1, 2'b11, 0, 2'b01, 0));
        v = nv(0, a1, a0, 2'b11, 0, 2'b00, 0);
        v.we = 2'b01; v.areg = {5'd0, 5'd7}; v.preg = {6'd0, 6'd20}; v.fv = 2'b01; v.fp = {6'd0, 6'd13};
        v.fl = 1; v.rpc = 32'h8000_0100;
        apply(v);
        apply(nv(0, a1, a0, 2'b11, 0, 2'b11, 0));
        // Exception store in slot 1: pops without store handshake, no arch write for it.
        v = nv(0, a0, x1, 2'b11, 0, 2'b11, 0);
        v.we = 2'b11; v.areg = {5'd3, 5'd4}; v.preg = {6'd10, 6'd11}; v.fv = 2'b11; v.fp = {6'd2, 6'd5};
        apply(v);
        v = nv(0, z, z, 2'b00, 0, 2'b00, 0);
        v.we = 2'b01; v.areg = {5'd0, 5'd3}; v.preg = {6'd0, 6'd10}; v.fv = 2'b01; v.fp = {6'd0, 6'd2};
        v.fl = 1; v.rpc = 32'h8000_0000; v.ev = 1; v.ec = 6'h0B; v.epc = 32'h0000_1004;
        apply(v);
        apply(nv(0, z, z, 2'b00, 0, 2'b00, 0));
        // Older store retires alongside a younger mispredict.
        apply(nv(0, s0, m0, 2'b11, 1, 2'b11, 1));
        v = nv(0, z, z, 2'b00, 1, 2'b00, 0);
        v.we = 2'b10; v.areg = {5'd7, 5'd0}; v.preg = {6'd20, 6'd0}; v.fv = 2'b10; v.fp = {6'd13, 6'd0};
        v.fl = 1; v.rpc = 32'h8000_0100;
        apply(v);
        apply(nv(0, z, z, 2'b00, 0, 2'b00, 0));
        // Reset asserted during FLUSH discards the flush.
        apply(nv(0, m0, z, 2'b01, 0, 2'b01, 0));
        v = nv(1, a0, z, 2'b01, 0, 2'b00, 0);
        v.we = 2'b01; v.areg = {5'd0, 5'd7}; v.preg = {6'd0, 6'd20}; v.fv = 2'b01; v.fp = {6'd0, 6'd13};
        v.fl = 1; v.rpc = 32'h8000_0100;
        apply(v);
        apply(nv(0, z, z, 2'b00, 0, 2'b00, 0));
        apply(nv(0, z, z, 2'b00, 0, 2'b00, 0));

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
